cv32e40p_hwloop_regs_ext: RTL and testbench

Parametrised hardware-loop register bank with N_REGS loop contexts. Each context holds a start address, an end address and an iteration counter. Beyond plain storage, the bank provides saturating decrement, per-loop active/done status, single-decrement arbitration and a registered nesting-order check. It sits between the EX-stage hwloop setup path and the hwloop controller in the ID stage.

---
 rtl/cv32e40p_hwloop_regs_ext.sv | 76 +++++++
 tb/tb_cv32e40p_hwloop_regs_ext.sv | 119 +++++++++++
 2 files changed

// File: rtl/cv32e40p_hwloop_regs_ext.sv
// cv32e40p_hwloop_regs_ext: hardware-loop context bank with saturating decrement, done/active status and nesting check
module cv32e40p_hwloop_regs_ext #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [ADDR_WIDTH-1:0]               hwlp_start_data_i,
  input  logic [ADDR_WIDTH-1:0]               hwlp_end_data_i,
  input  logic [CNT_WIDTH-1:0]                hwlp_cnt_data_i,
  input  logic [2:0]                          hwlp_we_i,
  input  logic [N_REG_BITS-1:0]               hwlp_regid_i,
  input  logic                                valid_i,
  input  logic [N_REGS-1:0]                   hwlp_dec_cnt_i,
  output logic [N_REGS-1:0][ADDR_WIDTH-1:0]   hwlp_start_addr_o,
  output logic [N_REGS-1:0][ADDR_WIDTH-1:0]   hwlp_end_addr_o,
  output logic [N_REGS-1:0][CNT_WIDTH-1:0]    hwlp_counter_o,
  output logic [N_REGS-1:0]                   hwlp_active_o,
  output logic [N_REGS-1:0]                   hwlp_done_o,
  output logic                                hwlp_multi_dec_o,
  output logic                                hwlp_nest_err_o
);
  logic [N_REGS-1:0][ADDR_WIDTH-1:0] r_start, r_end;
  logic [N_REGS-1:0][CNT_WIDTH-1:0]  r_cnt;
  logic [N_REGS-1:0]                 r_done, w_req, w_grant, w_active, w_nest, w_sel;
  logic                              r_multi, r_nest;
  always_comb begin
    w_req   = valid_i ? hwlp_dec_cnt_i : '0;
    w_grant = w_req & (~w_req + N_REGS'(1));
  end
  genvar i;
  generate
    for (i = 0; i < N_REGS; i++) begin : g_ctx
      assign w_sel[i]    = hwlp_regid_i == N_REG_BITS'(i);
      assign w_active[i] = r_cnt[i] != '0;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_start[i] <= '0;
          r_end[i]   <= '0;
          r_cnt[i]   <= '0;
          r_done[i]  <= 1'b0;
        end else begin
          if (hwlp_we_i[0] && w_sel[i]) r_start[i] <= hwlp_start_data_i & ~ADDR_WIDTH'(1);
          if (hwlp_we_i[1] && w_sel[i]) r_end[i] <= hwlp_end_data_i & ~ADDR_WIDTH'(1);
          if (hwlp_we_i[2] && w_sel[i]) r_cnt[i] <= hwlp_cnt_data_i;
          else if (w_grant[i] && w_active[i]) r_cnt[i] <= r_cnt[i] - CNT_WIDTH'(1);
          r_done[i] <= !(hwlp_we_i[2] && w_sel[i]) && w_grant[i] && r_cnt[i] == CNT_WIDTH'(1);
        end
      end
      // inner context k-1 must end no later than its enclosing context k
      if (i > 0) begin : g_nest
        assign w_nest[i] = w_active[i-1] && w_active[i] && r_end[i-1] > r_end[i];
      end else begin : g_nest0
        assign w_nest[i] = 1'b0;
      end
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (rst) begin
      r_multi <= 1'b0;
      r_nest  <= 1'b0;
    end else begin
      r_multi <= |(w_req & (w_req - N_REGS'(1)));
      r_nest  <= |w_nest;
    end
  end
  assign hwlp_start_addr_o = r_start;
  assign hwlp_end_addr_o   = r_end;
  assign hwlp_counter_o    = r_cnt;
  assign hwlp_active_o     = w_active;
  assign hwlp_done_o       = r_done;
  assign hwlp_multi_dec_o  = r_multi;
  assign hwlp_nest_err_o   = r_nest;
endmodule

// File: tb/tb_cv32e40p_hwloop_regs_ext.sv
// tb_cv32e40p_hwloop_regs_ext: directed self-checking bench for the hardware-loop register bank
module tb_cv32e40p_hwloop_regs_ext;
  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      start_d, end_d, cnt_d;
  logic [2:0]       we;
  logic [0:0]       regid;
  logic             valid;
  logic [1:0]       dec;
  logic [1:0][31:0] start_o, end_o, cnt_o;
  logic [1:0]       active, done;
  logic             multi, nest;
  int               checks = 0;
  int               errors = 0;

  cv32e40p_hwloop_regs_ext dut (
    .clk(clk), .rst(rst),
    .hwlp_start_data_i(start_d), .hwlp_end_data_i(end_d), .hwlp_cnt_data_i(cnt_d),
    .hwlp_we_i(we), .hwlp_regid_i(regid), .valid_i(valid), .hwlp_dec_cnt_i(dec),
    .hwlp_start_addr_o(start_o), .hwlp_end_addr_o(end_o), .hwlp_counter_o(cnt_o),
    .hwlp_active_o(active), .hwlp_done_o(done),
    .hwlp_multi_dec_o(multi), .hwlp_nest_err_o(nest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [0:0] id, input logic [2:0] w, input logic [31:0] s,
                    input logic [31:0] e, input logic [31:0] c);
    regid = id; we = w; start_d = s; end_d = e; cnt_d = c;
    @(negedge clk);
    we = 3'b000;
  endtask

  initial begin
    rst = 1'b1; start_d = '0; end_d = '0; cnt_d = '0; we = '0; regid = '0; valid = 1'b0; dec = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_cnt", cnt_o, 64'h0);
    chk("reset_active", active, 2'b00);
    chk("reset_done", done, 2'b00);
    chk("reset_multi", multi, 1'b0);
    chk("reset_nest", nest, 1'b0);
    // load state that would raise every flag, then reset over it
    wr(0, 3'b110, 32'h0, 32'h300, 32'd5);
    wr(1, 3'b110, 32'h0, 32'h200, 32'd4);
    chk("pre_rst_cnt", cnt_o, {32'd4, 32'd5});
    rst = 1'b1; valid = 1'b1; dec = 2'b11;
    @(negedge clk);
    rst = 1'b0; valid = 1'b0; dec = 2'b00;
    chk("rst_mid_cnt", cnt_o, 64'h0);
    chk("rst_mid_end", end_o, 64'h0);
    chk("rst_mid_multi", multi, 1'b0);
    chk("rst_mid_nest", nest, 1'b0);
    wr(1, 3'b111, 32'h103, 32'h200, 32'd3);
    chk("wr_start1", start_o[1], 32'h102);
    chk("wr_end1", end_o[1], 32'h200);
    chk("wr_cnt1", cnt_o[1], 32'd3);
    chk("wr_active", active, 2'b10);
    // countdown with saturation
    wr(0, 3'b100, 32'h0, 32'h0, 32'd2);
    chk("cd_load", cnt_o[0], 32'd2);
    valid = 1'b1; dec = 2'b01;
    @(negedge clk);
    chk("cd_cnt1", cnt_o[0], 32'd1);
    chk("cd_done1", done, 2'b00);
    @(negedge clk);
    chk("cd_cnt0", cnt_o[0], 32'd0);
    chk("cd_done_pulse", done, 2'b01);
    chk("cd_active", active, 2'b10);
    @(negedge clk);
    chk("cd_sat", cnt_o[0], 32'd0);
    chk("cd_done_off", done, 2'b00);
    valid = 1'b0; dec = 2'b00;
    // gating and write/decrement collision
    wr(0, 3'b100, 32'h0, 32'h0, 32'd1);
    valid = 1'b0; dec = 2'b01;
    @(negedge clk);
    chk("gate_cnt", cnt_o[0], 32'd1);
    chk("gate_done", done, 2'b00);
    valid = 1'b1;
    wr(0, 3'b100, 32'h0, 32'h0, 32'd7);
    chk("coll_cnt", cnt_o[0], 32'd7);
    chk("coll_done", done, 2'b00);
    valid = 1'b0; dec = 2'b00;
    // arbitration
    wr(0, 3'b100, 32'h0, 32'h0, 32'd5);
    wr(1, 3'b100, 32'h0, 32'h0, 32'd5);
    valid = 1'b1; dec = 2'b11;
    @(negedge clk);
    valid = 1'b0; dec = 2'b00;
    chk("arb_cnt0", cnt_o[0], 32'd4);
    chk("arb_cnt1", cnt_o[1], 32'd5);
    chk("arb_multi", multi, 1'b1);
    @(negedge clk);
    chk("arb_multi_off", multi, 1'b0);
    chk("arb_hold", cnt_o[0], 32'd4);
    // nesting: inner end beyond outer end
    chk("nest_idle", nest, 1'b0);
    wr(0, 3'b010, 32'h0, 32'h301, 32'h0);
    chk("nest_end0", end_o[0], 32'h300);
    chk("nest_lat", nest, 1'b0);
    @(negedge clk);
    chk("nest_set", nest, 1'b1);
    wr(0, 3'b100, 32'h0, 32'h0, 32'd0);
    chk("nest_hold", nest, 1'b1);
    @(negedge clk);
    chk("nest_clear", nest, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
